// File: rtl/rgb_downscale_2x2.sv
// rgb_downscale_2x2: streaming 2x2 box-filter downscaler for 24-bit RGB.
// Averages each non-overlapping 2x2 block per channel (truncating) and emits
// one pixel per block in raster order. The top row of each block is reduced
// to per-channel horizontal pair sums and parked in a half-width line buffer
// until the bottom row arrives.
module rgb_downscale_2x2 #(
  parameter int unsigned IN_WIDTH  = 1024,
  parameter int unsigned IN_HEIGHT = 576
) (
  input  logic        clock,
  input  logic        reset,
  output logic        in_rd_en,
  input  logic        in_empty,
  input  logic [23:0] in_dout,
  output logic        out_wr_en,
  input  logic        out_full,
  output logic [23:0] out_din,
  output logic        frame_done
);

  localparam int unsigned COL_W    = (IN_WIDTH  > 2) ? $clog2(IN_WIDTH)  : 1;
  localparam int unsigned ROW_W    = (IN_HEIGHT > 2) ? $clog2(IN_HEIGHT) : 1;
  localparam int unsigned ADDR_W   = (COL_W > 1) ? COL_W - 1 : 1;
  localparam int unsigned LB_DEPTH = IN_WIDTH / 2;
  localparam int unsigned PAIR_W   = 9;
  localparam int unsigned LB_W     = 3 * PAIR_W;
  localparam int unsigned SUM_W    = 10;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IN_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IN_HEIGHT - 1);

  typedef enum logic {
    S_IN  = 1'b0,
    S_OUT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [23:0]        h_q, h_d;
  logic [23:0]        out_din_q, out_din_d;
  logic               last_q, last_d;

  logic [LB_W-1:0]    linebuf [LB_DEPTH];
  logic [LB_W-1:0]    lb_rdata_q;
  logic [ADDR_W-1:0]  lb_addr;
  logic               lb_we;
  logic               lb_re;

  logic [LB_W-1:0]    pair_sum;
  logic [23:0]        blk_avg;
  logic [SUM_W-1:0]   blk_sum [3];

  assign lb_addr = ADDR_W'(col_q >> 1);
  assign out_din = out_din_q;

  // Per-channel horizontal pair sums and 2x2 block averages (no cross-channel carry)
  always_comb begin
    pair_sum = '0;
    blk_avg  = '0;
    for (int c = 0; c < 3; c++) begin
      pair_sum[c*PAIR_W +: PAIR_W] = PAIR_W'(h_q[c*8 +: 8]) + PAIR_W'(in_dout[c*8 +: 8]);
      blk_sum[c] = SUM_W'(lb_rdata_q[c*PAIR_W +: PAIR_W]) + SUM_W'(h_q[c*8 +: 8])
                 + SUM_W'(in_dout[c*8 +: 8]);
      blk_avg[c*8 +: 8] = blk_sum[c][SUM_W-1:2];
    end
  end

  // Next-state, counter advance and handshake decode
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    h_d        = h_q;
    out_din_d  = out_din_q;
    last_d     = last_q;
    lb_we      = 1'b0;
    lb_re      = 1'b0;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      S_IN: begin
        in_rd_en = !in_empty;
        if (!in_empty) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
          case ({row_q[0], col_q[0]})
            2'b00: h_d = in_dout;
            2'b01: lb_we = 1'b1;
            2'b10: begin
              h_d   = in_dout;
              lb_re = 1'b1;
            end
            default: begin
              out_din_d = blk_avg;
              last_d    = (row_q == LAST_ROW) && (col_q == LAST_COL);
              state_d   = S_OUT;
            end
          endcase
        end
      end
      S_OUT: begin
        out_wr_en = !out_full;
        if (!out_full) begin
          frame_done = last_q;
          state_d    = S_IN;
        end
      end
      default: state_d = S_IN;
    endcase

    // Nothing handshakes or touches the line buffer while reset is held
    if (reset) begin
      in_rd_en   = 1'b0;
      out_wr_en  = 1'b0;
      frame_done = 1'b0;
      lb_we      = 1'b0;
      lb_re      = 1'b0;
    end
  end

  // State, counters and datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IN;
      col_q     <= '0;
      row_q     <= '0;
      h_q       <= '0;
      out_din_q <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      h_q       <= h_d;
      out_din_q <= out_din_d;
      last_q    <= last_d;
    end
  end

  // Line buffer: single-port write, registered read; contents are never cleared
  always_ff @(posedge clock) begin
    if (lb_we) begin
      linebuf[lb_addr] <= pair_sum;
    end
    if (lb_re) begin
      lb_rdata_q <= linebuf[lb_addr];
    end
  end

endmodule
